// File: rtl/jtag_debug_cmd_sysclk_n.sv
// System-clock side of the JTAG debug command path: synchronises update-DR toggles,
// queues {IR, DR} captures and releases them as one-hot action / no-action strobes.
module jtag_debug_cmd_sysclk_n #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int ACTION_BIT  = 34,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          udr_toggle,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [DR_WIDTH-1:0]           sr,
    input  logic                          cmd_ready,
    input  logic                          clr_overflow,
    output logic                          cmd_valid,
    output logic [IR_WIDTH-1:0]           cmd_ir,
    output logic [DR_WIDTH-1:0]           jdo,
    output logic [2**IR_WIDTH-1:0]        take_action,
    output logic [2**IR_WIDTH-1:0]        take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int NCODES = 2**IR_WIDTH;
    localparam int ACW    = $clog2(SYNC_STAGES + 2);
    localparam logic [ACW-1:0] ARM_LAST  = ACW'(SYNC_STAGES);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    generate
        if (ACTION_BIT >= DR_WIDTH) begin : g_bad_action_bit
            $error("ACTION_BIT must be below DR_WIDTH");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("SYNC_STAGES must be in 2..4");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic [ACW-1:0]         arm_cnt_reg;
    logic                   armed_reg;
    logic                   udr_event;

    // The arm delay lets the chain settle to whatever level the TCK side holds,
    // so a stale toggle left over from before reset is never seen as an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= '0;
            prev_reg    <= 1'b0;
            arm_cnt_reg <= '0;
            armed_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], udr_toggle};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            if (!armed_reg) begin
                if (arm_cnt_reg == ARM_LAST) begin
                    armed_reg <= 1'b1;
                end else begin
                    arm_cnt_reg <= arm_cnt_reg + ACW'(1);
                end
            end
        end
    end

    assign udr_event = armed_reg & (sync_reg[SYNC_STAGES-1] ^ prev_reg);

    logic [IR_WIDTH-1:0] ir_mem [FIFO_DEPTH];
    logic [DR_WIDTH-1:0] dr_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [AW:0]         count_reg;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;
    logic [IR_WIDTH-1:0] head_ir;
    logic [DR_WIDTH-1:0] head_dr;

    assign full      = (count_reg == DEPTH_CNT);
    assign cmd_valid = (count_reg != '0);
    assign pop       = cmd_valid & cmd_ready;
    // A pop frees the head slot on the same edge, so a full queue can still accept.
    assign push      = udr_event & (~full | pop);
    assign drop      = udr_event & full & ~pop;
    assign head_ir   = ir_mem[rd_ptr_reg];
    assign head_dr   = dr_mem[rd_ptr_reg];
    assign cmd_ir    = cmd_valid ? head_ir : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_reg] <= ir_in;
            dr_mem[wr_ptr_reg] <= sr;
        end
    end

    logic [NCODES-1:0] code_hit;
    logic [NCODES-1:0] action_next;
    logic [NCODES-1:0] no_action_next;
    logic [NCODES-1:0] take_action_reg;
    logic [NCODES-1:0] take_no_action_reg;
    logic [DR_WIDTH-1:0] jdo_reg;
    logic                overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCODES; gi++) begin : g_strobe
            assign code_hit[gi]       = pop && (head_ir == IR_WIDTH'(gi));
            assign action_next[gi]    = code_hit[gi] &  head_dr[ACTION_BIT];
            assign no_action_next[gi] = code_hit[gi] & ~head_dr[ACTION_BIT];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            jdo_reg            <= '0;
            take_action_reg    <= '0;
            take_no_action_reg <= '0;
            overflow_reg       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                jdo_reg    <= head_dr;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            take_action_reg    <= action_next;
            take_no_action_reg <= no_action_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign jdo            = jdo_reg;
    assign take_action    = take_action_reg;
    assign take_no_action = take_no_action_reg;
    assign fifo_count     = count_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_n.sv
// Bench for jtag_debug_cmd_sysclk_n: directed scenarios plus random traffic scored
// against a time-based queue model; a second instance covers a wider configuration.
module tb_jtag_debug_cmd_sysclk_n;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int AB = 34;

    logic        clk = 1'b0;
    logic        reset, udr_toggle, cmd_ready, clr_overflow;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid, overflow;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action, take_no_action;
    logic [2:0]  fifo_count;

    logic        reset2, tog2, ready2, clr2;
    logic [2:0]  ir2;
    logic [39:0] sr2;
    logic        cmd_valid2, overflow2;
    logic [2:0]  cmd_ir2;
    logic [39:0] jdo2;
    logic [7:0]  take_action2, take_no_action2;
    logic [3:0]  fifo_count2;

    always #5 clk = ~clk;

    jtag_debug_cmd_sysclk_n dut (
        .clk(clk), .reset(reset), .udr_toggle(udr_toggle), .ir_in(ir_in), .sr(sr),
        .cmd_ready(cmd_ready), .clr_overflow(clr_overflow), .cmd_valid(cmd_valid),
        .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
        .take_no_action(take_no_action), .fifo_count(fifo_count), .overflow(overflow)
    );

    jtag_debug_cmd_sysclk_n #(
        .IR_WIDTH(3), .DR_WIDTH(40), .ACTION_BIT(34), .SYNC_STAGES(3), .FIFO_DEPTH(8)
    ) dut2 (
        .clk(clk), .reset(reset2), .udr_toggle(tog2), .ir_in(ir2), .sr(sr2),
        .cmd_ready(ready2), .clr_overflow(clr2), .cmd_valid(cmd_valid2),
        .cmd_ir(cmd_ir2), .jdo(jdo2), .take_action(take_action2),
        .take_no_action(take_no_action2), .fifo_count(fifo_count2), .overflow(overflow2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of commands plus the edge number at which each
    // toggle flip becomes visible (flip after edge N lands on edge N+S+1).
    typedef struct packed {
        logic [1:0]  ir;
        logic [37:0] dr;
    } cmd_t;

    cmd_t        q[$];
    int          due[$];
    int          cyc = 0;
    int          last_rst = 0;
    logic [37:0] m_jdo = '0;
    logic [3:0]  m_ta = '0, m_tna = '0;
    logic        m_ovf = 1'b0;

    task automatic flip();
        udr_toggle = ~udr_toggle;
        // Only flips made after the first post-reset edge survive arming.
        if (cyc > last_rst) due.push_back(cyc + S + 1);
    endtask

    task automatic cycle();
        cmd_t head, entry;
        logic pop_e, push_e;
        pop_e  = 1'b0;
        push_e = 1'b0;
        if (reset) begin
            q.delete();
            due.delete();
            m_jdo    = '0;
            m_ta     = '0;
            m_tna    = '0;
            m_ovf    = 1'b0;
            last_rst = cyc + 1;
        end else begin
            pop_e = (q.size() > 0) && cmd_ready;
            if (due.size() > 0 && due[0] == cyc + 1) begin
                void'(due.pop_front());
                push_e = 1'b1;
            end
            m_ta  = '0;
            m_tna = '0;
            if (pop_e) begin
                head  = q.pop_front();
                m_jdo = head.dr;
                if (head.dr[AB]) m_ta[head.ir] = 1'b1;
                else             m_tna[head.ir] = 1'b1;
                $display("release ir=%0d dr=%h action=%0d", head.ir, head.dr, head.dr[AB]);
            end
            if (push_e && q.size() == D) begin
                m_ovf = 1'b1;
            end else begin
                if (push_e) begin
                    entry.ir = ir_in;
                    entry.dr = sr;
                    q.push_back(entry);
                end
                if (clr_overflow) m_ovf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("cmd_valid", 64'(cmd_valid), 64'(q.size() > 0));
        check("cmd_ir", 64'(cmd_ir), (q.size() > 0) ? 64'(q[0].ir) : 64'd0);
        check("fifo_count", 64'(fifo_count), 64'(q.size()));
        check("jdo", 64'(jdo), 64'(m_jdo));
        check("take_action", 64'(take_action), 64'(m_ta));
        check("take_no_action", 64'(take_no_action), 64'(m_tna));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic queue_cmd(input logic [1:0] ir, input logic [37:0] dr, input int gap);
        ir_in = ir;
        sr    = dr;
        flip();
        repeat (gap) cycle();
    endtask

    initial begin
        logic [7:0] exp8;
        int gap;
        reset = 1'b1; udr_toggle = 1'b1; cmd_ready = 1'b0; clr_overflow = 1'b0;
        ir_in = '0; sr = '0;
        reset2 = 1'b1; tog2 = 1'b0; ready2 = 1'b0; clr2 = 1'b0; ir2 = '0; sr2 = '0;

        // Toggle level held high through reset must not produce a command.
        repeat (3) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        check("arm_no_event", 64'(cmd_valid), 64'd0);

        // Single action command and its latency.
        cmd_ready = 1'b1;
        ir_in = 2'b01; sr = 38'h04_0000_1234;
        flip();
        repeat (S) cycle();
        check("lat_early", 64'(cmd_valid), 64'd0);
        cycle();
        check("lat_valid", 64'(cmd_valid), 64'd1);
        cycle();
        check("single_ta", 64'(take_action), 64'h2);
        check("single_jdo", 64'(jdo), 64'h04_0000_1234);
        cycle();
        check("single_ta_clear", 64'(take_action), 64'd0);

        // No-action path.
        queue_cmd(2'b11, 38'h00_dead_0042, 6);

        // Fill past capacity, then drain and clear the sticky flag.
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) queue_cmd(2'(i), {4'(i), 34'(i * 7)} | (38'(i[0]) << AB), 6);
        check("fill_count", 64'(fifo_count), 64'd4);
        check("fill_ovf", 64'(overflow), 64'd1);
        cmd_ready = 1'b1;
        repeat (6) cycle();
        check("drain_empty", 64'(cmd_valid), 64'd0);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full queue: an event landing on the same edge as a pop is accepted.
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) queue_cmd(2'(3 - i), 38'h3f_0000_0000 | 38'(i), 6);
        ir_in = 2'b10; sr = 38'h04_5555_aaaa;
        flip();
        repeat (S) cycle();
        cmd_ready = 1'b1;
        cycle();
        cmd_ready = 1'b0;
        check("fullpop_count", 64'(fifo_count), 64'd4);
        check("fullpop_ovf", 64'(overflow), 64'd0);
        cmd_ready = 1'b1;
        repeat (6) cycle();

        // Reset asserted on a pop edge.
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) queue_cmd(2'(i), 38'h3f_ffff_ffff ^ 38'(i), 6);
        cmd_ready = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_ta", 64'(take_action | take_no_action), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        reset = 1'b0;
        repeat (S + 3) cycle();
        queue_cmd(2'b00, 38'h04_0000_0001, 8);

        // Random traffic.
        gap = 0;
        for (int i = 0; i < 600; i++) begin
            cmd_ready    = ($urandom_range(0, 2) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 249) == 0);
            if (due.size() == 0 && gap == 0 && $urandom_range(0, 1) == 0) begin
                ir_in = 2'($urandom);
                sr    = 38'({$urandom, $urandom});
                flip();
                gap = S + 1 + int'($urandom_range(0, 3));
            end
            cycle();
            if (gap > 0) gap--;
        end
        reset = 1'b0; cmd_ready = 1'b1; clr_overflow = 1'b0;
        repeat (12) cycle();

        // Wider configuration: latency 5 edges counting the flip edge, 8-bit one-hot strobes.
        reset2 = 1'b0;
        repeat (6) cycle();
        for (int k = 0; k < 6; k++) begin
            ir2 = 3'($urandom);
            sr2 = {8'($urandom), $urandom};
            ready2 = 1'b0;
            tog2 = ~tog2;
            repeat (3) begin
                cycle();
                check("sw_early", 64'(cmd_valid2), 64'd0);
            end
            cycle();
            check("sw_valid", 64'(cmd_valid2), 64'd1);
            check("sw_cmd_ir", 64'(cmd_ir2), 64'(ir2));
            ready2 = 1'b1;
            cycle();
            exp8 = 8'd1 << ir2;
            check("sw_ta", 64'(take_action2), sr2[34] ? 64'(exp8) : 64'd0);
            check("sw_tna", 64'(take_no_action2), sr2[34] ? 64'd0 : 64'(exp8));
            check("sw_jdo", 64'(jdo2), 64'(sr2));
            ready2 = 1'b0;
            cycle();
            check("sw_strobe_clear", 64'(take_action2 | take_no_action2), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_debug_cmd_sysclk_n.md
Name: jtag_debug_cmd_sysclk_n

Overview:
- System-clock half of the CPU JTAG debug path, generalised successor to the fixed 2-bit-IR / 38-bit-DR sysclk decoder.
- Receives update-DR events from the TCK-domain shift logic as a level toggle and synchronises them internally.
- Queues each captured {IR, DR} pair in a small FIFO and releases entries through a valid/ready handshake.
- On each release, pulses a one-hot take_action or take_no_action strobe per IR code, with a stable jdo alongside.

Parameters:
IR_WIDTH, 2, width of the virtual-JTAG instruction register
DR_WIDTH, 38, width of the shifted data register (sr / jdo)
ACTION_BIT, 34, bit of the DR that selects take_action (1) vs take_no_action (0)
SYNC_STAGES, 2, flops in the toggle synchroniser (legal range 2..4)
FIFO_DEPTH, 4, command queue entries (power of two, at least 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
udr_toggle  in  1  TCK-domain level that inverts once per update-DR
ir_in  in  IR_WIDTH  TCK-domain IR; stable from toggle edge until next update-IR
sr  in  DR_WIDTH  TCK-domain shift register; stable for at least SYNC_STAGES+2 clk after toggle edge
cmd_ready  in  1  consumer can accept the head entry
clr_overflow  in  1  clears the overflow flag
cmd_valid  out  1  FIFO non-empty
cmd_ir  out  IR_WIDTH  IR of head entry
jdo  out  DR_WIDTH  DR of most recently released entry (held)
take_action  out  2**IR_WIDTH  one-cycle one-hot strobe, index = released IR, ACTION_BIT=1
take_no_action  out  2**IR_WIDTH  one-cycle one-hot strobe, index = released IR, ACTION_BIT=0
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset values:
  - all outputs 0 (cmd_ir 0, jdo 0);
  - FIFO empty, pointers 0;
  - sync chain 0, prev 0, arm counter 0, armed 0.
- Synchroniser: s[0] <= udr_toggle; s[k] <= s[k-1]; prev <= s[SYNC_STAGES-1] every cycle.
- Arming: after reset, arm counter counts SYNC_STAGES+1 cycles, then sets armed.
  - event = armed & (s[SYNC_STAGES-1] ^ prev).
  - A toggle level present at reset release never produces an event.
- Push: on an event cycle, {ir_in, sr} is sampled at that clock edge and written at the tail.
  - Latency from toggle change to cmd_valid = SYNC_STAGES+2 edges when the FIFO is empty and armed.
- Pop: occurs at any edge with cmd_valid & cmd_ready. On the same edge:
  - jdo <= head DR;
  - take_action[head IR] <= head DR[ACTION_BIT];
  - take_no_action[head IR] <= ~head DR[ACTION_BIT].
  - Strobes are high exactly one cycle, then return to 0. Neither strobe fires on cycles without a pop.
  - Back-to-back pops give consecutive strobe cycles.
- cmd_ir and cmd_valid are combinational from FIFO state: registered pointers, no bypass.
- Full:
  - An event with count = FIFO_DEPTH and no pop that edge is dropped and sets overflow.
  - An event coinciding with a pop while full is accepted; count is unchanged.
- Empty: cmd_ready while empty has no effect; no strobes, jdo held.
- Simultaneous push and pop, any non-full count: count is unchanged; the head pops, and the tail writes the new entry.
- Overflow: clr_overflow clears it. If a drop occurs in the same cycle, set wins.
- Pointer wrap: modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH by construction.
- Reset mid-operation:
  - the queue is flushed, strobes drop next cycle, and jdo returns to 0;
  - re-arming is required, so toggles in flight during reset are discarded.
- Width rules:
  - ACTION_BIT < DR_WIDTH is checked by an elaboration assertion;
  - an out-of-range IR code cannot occur because the strobe width is 2**IR_WIDTH.

Test Plan:
- Arming: hold udr_toggle=1 through reset, release reset, run 10 cycles -> cmd_valid stays 0, fifo_count 0.
- Single command: ir_in=2'b01, sr=38'h04_0000_1234 (bit 34=1), flip toggle, cmd_ready=1.
  - cmd_valid rises after SYNC_STAGES+2 edges.
  - Next cycle take_action=4'b0010 for one cycle, jdo=38'h04_0000_1234, take_no_action=0.
- No-action path: ir_in=2'b11, sr bit 34=0 -> take_no_action=4'b1000 one cycle, take_action=0.
- Fill and overflow: cmd_ready=0, 5 toggles spaced 6 cycles, DEPTH=4.
  - fifo_count=4, overflow=1.
  - Drain with ready=1 -> 4 strobes in entry order, then cmd_valid=0.
  - clr_overflow -> overflow=0.
- Full with simultaneous pop: FIFO full, event arrives on the same edge as a pop -> count stays 4, overflow stays 0, new entry is delivered last.
- Reset mid-drain: 3 entries queued, assert reset during a pop cycle.
  - Next cycle all strobes 0, jdo 0, fifo_count 0.
  - A subsequent toggle after re-arm is delivered normally.
- Parameter sweep: IR_WIDTH=3, DR_WIDTH=40, SYNC_STAGES=3, FIFO_DEPTH=8 -> latency 5 edges, take_action width 8, one-hot index matches ir_in.
